sad_best_match: RTL and testbench
=================================

Name: sad_best_match

Overview:
- Downstream consumer of the partial-sum SAD core.
- Collects one SAD result per candidate block over a search window of N_CAND candidates, using a 4-phase done/ack handshake with the core.
- Tracks the minimum SAD and the index of the candidate that produced it.
- Presents the best match to the motion-estimation controller and holds it until that controller acknowledges.

Parameters:
- WIDTH, 8, pixel width; must match the SAD core.
- SAD_W, WIDTH+5, SAD result width (32 pixels: max 32*255 = 8160 fits 13 bits).
- N_CAND, 16, candidates per search; legal range 2..256.
- IDX_W, $clog2(N_CAND), width of the candidate index.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-low reset; 0 = reset.
- start  in  1  begin a new search; sampled only in IDLE.
- sad_done  in  1  SAD core result valid (core's out_done); held high until acked.
- sad_in  in  SAD_W  SAD core result (core's out_sad).
- sad_ack  out  1  acknowledge to the SAD core (drives the core's ack).
- busy  out  1  high in WAIT and RELEASE.
- result_valid  out  1  best-match result available.
- best_sad  out  SAD_W  minimum SAD of the search.
- best_idx  out  IDX_W  candidate index (0-based, arrival order) of best_sad.
- result_ack  in  1  controller has consumed the result.

Behaviour:
- Reset (rst=0, asynchronous) forces:
  - state = IDLE, cnt = 0
  - sad_ack = 0, busy = 0, result_valid = 0
  - best_sad = all-ones, best_idx = 0
- Reset mid-search aborts the search; no partial result is ever flagged.
- All outputs are registered.
- States: IDLE, WAIT, RELEASE, RESULT.
- IDLE:
  - start=1: cnt<=0, best_sad<=all-ones, best_idx<=0, go to WAIT.
  - sad_done is ignored in IDLE; no ack is given, so the core stalls until a search starts.
- WAIT:
  - On the edge where sad_done=1:
    - Compare sad_in against best_sad.
    - If cnt==0 OR sad_in < best_sad (strict less-than): best_sad<=sad_in, best_idx<=cnt.
    - cnt<=cnt+1, sad_ack<=1, go to RELEASE.
  - Ties keep the earlier index.
  - sad_ack rises 1 cycle after sad_done is first sampled high.
- RELEASE:
  - sad_ack stays 1 while sad_done=1.
  - On the edge where sad_done=0: sad_ack<=0.
  - Then go to RESULT if cnt==N_CAND, else to WAIT.
  - A result is therefore counted exactly once, even if sad_done is held high for many cycles.
- RESULT:
  - result_valid=1; best_sad and best_idx are stable.
  - result_ack=1: result_valid<=0, go to IDLE.
  - start is ignored in RESULT, including when it arrives together with result_ack. A new search needs start in a later IDLE cycle.
- start outside IDLE is ignored.
- result_ack outside RESULT is ignored.
- cnt width is IDX_W+1 so it can reach N_CAND without wrapping.
- best_sad/best_idx keep their last value after RESULT until the next start.

Optional Feature:
- Macro: SAD_EARLY_EXIT_EN.
- Defined:
  - In WAIT, a captured sad_in==0 is an exact match: the search ends after the current RELEASE completes, going to RESULT regardless of cnt.
  - Remaining candidates are not consumed.
  - An extra output, early_exit (1 bit, reset 0), is set on entry to RESULT via this path and cleared on result_ack.
- Not defined:
  - A zero SAD is treated like any other value; all N_CAND candidates are always consumed.
  - No early_exit port exists.

Decomposition:
- Package sad_pkg holds:
  - SAD_W derivation function (WIDTH+5)
  - state enum {IDLE, WAIT, RELEASE, RESULT}
  - BEST_INIT constant (all-ones of SAD_W)
- One natural sub-module, sad_min_reg, containing:
  - the best_sad/best_idx registers
  - the strict-less comparator
  - the first-candidate load
- The FSM and counter stay in sad_best_match.

Test Plan:
- N_CAND=4, SADs 120, 45, 300, 45 (core holds sad_done 3 cycles each) -> best_sad=45, best_idx=1, exactly 4 sad_ack pulses, result_valid until result_ack.
- N_CAND=4, all SADs 8160 -> best_sad=8160, best_idx=0 (first-candidate load; ties keep index 0).
- sad_done asserted in IDLE for 10 cycles, then start -> no ack before start; that result is counted as candidate 0 after start.
- rst=0 pulsed mid-search after 2 of 4 candidates -> all outputs at reset values immediately (asynchronous); next start gives a clean search with best_idx relative to the new start.
- start and result_ack asserted together in RESULT -> returns to IDLE and no new search begins; start one cycle later enters WAIT.
- SAD_EARLY_EXIT_EN defined, N_CAND=16, SADs 70, 0, ... -> RESULT after 2 acks, best_sad=0, best_idx=1, early_exit=1; undefined build -> 16 acks, same best.

Source files
------------

// File: rtl/sad_pkg.sv
// Shared types and constants for the SAD best-match collector.
// Optional build macro: SAD_EARLY_EXIT_EN (exact-match early exit).
package sad_pkg;

  localparam int SAD_W_MAX = 32;
  localparam logic [SAD_W_MAX-1:0] BEST_INIT = '1;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RELEASE,
    RESULT
  } state_t;

  function automatic int sad_w(input int width);
    return width + 5;
  endfunction

endpackage

// File: rtl/sad_best_match_if.sv
// Core-side and controller-side handshake bundle for sad_best_match.
// Optional build macro: SAD_EARLY_EXIT_EN adds early_exit.
interface sad_best_match_if #(
  parameter int WIDTH  = 8,
  parameter int N_CAND = 16
);
  import sad_pkg::*;

  localparam int SAD_W = sad_w(WIDTH);
  localparam int IDX_W = $clog2(N_CAND);

  logic             start;
  logic             sad_done;
  logic [SAD_W-1:0] sad_in;
  logic             sad_ack;
  logic             busy;
  logic             result_valid;
  logic [SAD_W-1:0] best_sad;
  logic [IDX_W-1:0] best_idx;
  logic             result_ack;
`ifdef SAD_EARLY_EXIT_EN
  logic             early_exit;

  modport master (
    output start, sad_done, sad_in, result_ack,
    input  sad_ack, busy, result_valid,
    input  best_sad, best_idx, early_exit
  );

  modport slave (
    input  start, sad_done, sad_in, result_ack,
    output sad_ack, busy, result_valid,
    output best_sad, best_idx, early_exit
  );
`else
  modport master (
    output start, sad_done, sad_in, result_ack,
    input  sad_ack, busy, result_valid,
    input  best_sad, best_idx
  );

  modport slave (
    input  start, sad_done, sad_in, result_ack,
    output sad_ack, busy, result_valid,
    output best_sad, best_idx
  );
`endif

endinterface

// File: rtl/sad_min_reg.sv
// Running minimum of SAD results with arrival index.
// First candidate always loads; later ones only on strict less-than.
module sad_min_reg
  import sad_pkg::*;
#(
  parameter int SAD_W = 13,
  parameter int IDX_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             load,
  input  logic             first,
  input  logic [SAD_W-1:0] sad_in,
  input  logic [IDX_W-1:0] idx,
  output logic [SAD_W-1:0] best_sad,
  output logic [IDX_W-1:0] best_idx
);

  logic take;

  assign take = first || (sad_in < best_sad);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      best_sad <= BEST_INIT[SAD_W-1:0];
      best_idx <= '0;
    end else if (clr) begin
      best_sad <= BEST_INIT[SAD_W-1:0];
      best_idx <= '0;
    end else if (load && take) begin
      best_sad <= sad_in;
      best_idx <= idx;
    end
  end

endmodule

// File: rtl/sad_best_match.sv
// Collects N_CAND SAD results via done/ack and reports the best match.
// Optional build macro: SAD_EARLY_EXIT_EN (stop on a zero SAD).
module sad_best_match
  import sad_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int N_CAND = 16
) (
  input  logic             clk,
  input  logic             rst,
  sad_best_match_if.slave  bus
);

  localparam int SAD_W = sad_w(WIDTH);
  localparam int IDX_W = $clog2(N_CAND);
  localparam int CNT_W = IDX_W + 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(N_CAND);

  state_t           state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic             ack, ack_n;
  logic             busy, busy_n;
  logic             rv, rv_n;
  logic             load, clr;
  logic             finish;
`ifdef SAD_EARLY_EXIT_EN
  logic             zero_hit, zero_n;
  logic             early, early_n;
`endif

`ifdef SAD_EARLY_EXIT_EN
  assign finish = (cnt == LAST) || zero_hit;
`else
  assign finish = (cnt == LAST);
`endif

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    ack_n   = ack;
    rv_n    = rv;
    load    = 1'b0;
    clr     = 1'b0;
`ifdef SAD_EARLY_EXIT_EN
    zero_n  = zero_hit;
    early_n = early;
`endif
    unique case (state)
      IDLE: begin
        if (bus.start) begin
          clr     = 1'b1;
          cnt_n   = '0;
          state_n = WAIT;
`ifdef SAD_EARLY_EXIT_EN
          zero_n  = 1'b0;
`endif
        end
      end
      WAIT: begin
        if (bus.sad_done) begin
          load    = 1'b1;
          cnt_n   = cnt + 1'b1;
          ack_n   = 1'b1;
          state_n = RELEASE;
`ifdef SAD_EARLY_EXIT_EN
          zero_n  = (bus.sad_in == '0);
`endif
        end
      end
      RELEASE: begin
        // ack drops only once the core releases done: one count per result
        if (!bus.sad_done) begin
          ack_n = 1'b0;
          if (finish) begin
            state_n = RESULT;
            rv_n    = 1'b1;
`ifdef SAD_EARLY_EXIT_EN
            early_n = zero_hit;
`endif
          end else begin
            state_n = WAIT;
          end
        end
      end
      RESULT: begin
        if (bus.result_ack) begin
          rv_n    = 1'b0;
          state_n = IDLE;
`ifdef SAD_EARLY_EXIT_EN
          early_n = 1'b0;
`endif
        end
      end
      default: state_n = IDLE;
    endcase
    busy_n = (state_n == WAIT) || (state_n == RELEASE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      cnt      <= '0;
      ack      <= 1'b0;
      busy     <= 1'b0;
      rv       <= 1'b0;
`ifdef SAD_EARLY_EXIT_EN
      zero_hit <= 1'b0;
      early    <= 1'b0;
`endif
    end else begin
      state    <= state_n;
      cnt      <= cnt_n;
      ack      <= ack_n;
      busy     <= busy_n;
      rv       <= rv_n;
`ifdef SAD_EARLY_EXIT_EN
      zero_hit <= zero_n;
      early    <= early_n;
`endif
    end
  end

  sad_min_reg #(
    .SAD_W(SAD_W),
    .IDX_W(IDX_W)
  ) u_min (
    .clk     (clk),
    .rst     (rst),
    .clr     (clr),
    .load    (load),
    .first   (cnt == '0),
    .sad_in  (bus.sad_in),
    .idx     (cnt[IDX_W-1:0]),
    .best_sad(bus.best_sad),
    .best_idx(bus.best_idx)
  );

  assign bus.sad_ack      = ack;
  assign bus.busy         = busy;
  assign bus.result_valid = rv;
`ifdef SAD_EARLY_EXIT_EN
  assign bus.early_exit   = early;
`endif

endmodule

// File: tb/tb_sad_best_match.sv
// Bench for sad_best_match: emulated SAD core plus min-search model.
// Honours SAD_EARLY_EXIT_EN when the design is built with it.
module tb_sad_best_match;
  import sad_pkg::*;

  localparam int WIDTH = 8;
  localparam int N     = 4;
  localparam int SAD_W = 13;
`ifdef SAD_EARLY_EXIT_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  sad_best_match_if #(.WIDTH(WIDTH), .N_CAND(N)) bus ();

  sad_best_match #(.WIDTH(WIDTH), .N_CAND(N)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int checks = 0;
  int failures = 0;
  int exp_sad = 0;
  int exp_idx = 0;
  int ack_rises = 0;
  logic ack_q = 1'b0;
  int cand[$];

  function automatic void chk(input string name, input longint act,
                              input longint req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endfunction

  // Best match = first occurrence of the minimum over consumed candidates.
  function automatic void model(output int n, output int bs,
                                output int bi, output bit ee);
    n = 0; bs = 0; bi = 0; ee = 1'b0;
    foreach (cand[i]) begin
      if (i == 0 || cand[i] < bs) begin
        bs = cand[i];
        bi = i;
      end
      n++;
      if (EARLY && cand[i] == 0) begin
        ee = 1'b1;
        break;
      end
    end
  endfunction

  always @(negedge clk) begin
    if (bus.sad_ack && !ack_q) ack_rises++;
    ack_q = bus.sad_ack;
    if (rst && bus.result_valid) begin
      chk("cyc_best_sad", bus.best_sad, exp_sad);
      chk("cyc_best_idx", bus.best_idx, exp_idx);
    end
  end

  task automatic core_xfer(input int v, input int hold);
    bit got;
    @(negedge clk);
    bus.sad_done = 1'b1;
    bus.sad_in   = SAD_W'(v);
    got = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (bus.sad_ack) begin
        got = 1'b1;
        break;
      end
    end
    chk("ack_rise_seen", got, 1);
    repeat (hold) @(negedge clk);
    chk("ack_held", bus.sad_ack, 1);
    bus.sad_done = 1'b0;
    got = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (!bus.sad_ack) begin
        got = 1'b1;
        break;
      end
    end
    chk("ack_fall_seen", got, 1);
  endtask

  task automatic do_search(input int hold, input bit start_with_ack);
    int n, bs, bi, a0;
    bit ee, got;
    model(n, bs, bi, ee);
    exp_sad = bs;
    exp_idx = bi;
    a0 = ack_rises;
    @(negedge clk);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    chk("busy_after_start", bus.busy, 1);
    for (int i = 0; i < n; i++) core_xfer(cand[i], hold);
    got = 1'b0;
    for (int k = 0; k < 10; k++) begin
      if (bus.result_valid) begin
        got = 1'b1;
        break;
      end
      @(negedge clk);
    end
    chk("result_valid", got, 1);
    chk("ack_count", ack_rises - a0, n);
    chk("best_sad", bus.best_sad, bs);
    chk("best_idx", bus.best_idx, bi);
`ifdef SAD_EARLY_EXIT_EN
    chk("early_exit", bus.early_exit, ee);
`endif
    repeat (2) @(negedge clk);
    chk("rv_hold", bus.result_valid, 1);
    bus.result_ack = 1'b1;
    if (start_with_ack) bus.start = 1'b1;
    @(negedge clk);
    bus.result_ack = 1'b0;
    bus.start = 1'b0;
    chk("rv_clear", bus.result_valid, 0);
    chk("busy_idle", bus.busy, 0);
`ifdef SAD_EARLY_EXIT_EN
    chk("early_clear", bus.early_exit, 0);
`endif
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    int a0, pick, v;
    bit seen;
    bus.start = 1'b0;
    bus.sad_done = 1'b0;
    bus.sad_in = '0;
    bus.result_ack = 1'b0;

    repeat (2) @(negedge clk);
    chk("rst_rv", bus.result_valid, 0);
    chk("rst_ack", bus.sad_ack, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_best_sad", bus.best_sad, 8191);
    chk("rst_best_idx", bus.best_idx, 0);
    rst = 1'b1;
    @(negedge clk);

    cand = '{120, 45, 300, 45};
    do_search(3, 1'b0);
    chk("pin_tie_sad", bus.best_sad, 45);
    chk("pin_tie_idx", bus.best_idx, 1);

    cand = '{8160, 8160, 8160, 8160};
    do_search(1, 1'b0);
    chk("pin_max_sad", bus.best_sad, 8160);
    chk("pin_max_idx", bus.best_idx, 0);

    cand = '{77, 300, 2, 500};
    bus.sad_done = 1'b1;
    bus.sad_in = SAD_W'(77);
    seen = 1'b0;
    repeat (10) begin
      @(negedge clk);
      if (bus.sad_ack) seen = 1'b1;
    end
    chk("no_ack_in_idle", seen, 0);
    do_search(1, 1'b0);

    cand = '{900, 10, 10, 600};
    @(negedge clk);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    core_xfer(5, 1);
    core_xfer(6, 1);
    #3 rst = 1'b0;
    #1;
    chk("arst_rv", bus.result_valid, 0);
    chk("arst_ack", bus.sad_ack, 0);
    chk("arst_busy", bus.busy, 0);
    chk("arst_best_sad", bus.best_sad, 8191);
    chk("arst_best_idx", bus.best_idx, 0);
    @(negedge clk);
    rst = 1'b1;
    do_search(2, 1'b0);
    chk("pin_after_rst_idx", bus.best_idx, 1);

    cand = '{400, 399, 401, 7};
    do_search(1, 1'b1);
    @(negedge clk);
    chk("no_restart", bus.busy, 0);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    chk("late_start_busy", bus.busy, 1);
    cand = '{50, 60, 40, 40};
    do_search(1, 1'b0);

    cand = '{70, 0, 500, 20};
    a0 = ack_rises;
    do_search(1, 1'b0);
    chk("pin_zero_sad", bus.best_sad, 0);
    chk("pin_zero_idx", bus.best_idx, 1);
    chk("pin_zero_acks", ack_rises - a0, EARLY ? 2 : 4);

    for (int r = 0; r < 10; r++) begin
      cand.delete();
      for (int i = 0; i < N; i++) begin
        pick = int'($urandom_range(0, 9));
        if (pick < 3) v = 100;
        else if (pick == 9) v = 0;
        else v = int'($urandom_range(1, 8160));
        cand.push_back(v);
      end
      do_search(int'($urandom_range(1, 4)), 1'b0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
